// File: rtl/pupil_locator_pkg.sv
// Shared capture-window geometry and scan FSM encoding for the pupil locator.
// The frame-capture stage uses the same window size and addressing.
package pupil_locator_pkg;

    localparam int H_RES      = 160;
    localparam int V_RES      = 120;
    localparam int DATA_W     = 10;
    localparam int ADDR_W     = 15;
    localparam int COORD_W    = 8;
    localparam int MIN_PIXELS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/pupil_locator_if.sv
// Frame RAM read port: address out, data back one cycle later.
interface pupil_locator_if #(
    parameter int ADDR_W = pupil_locator_pkg::ADDR_W,
    parameter int DATA_W = pupil_locator_pkg::DATA_W
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    modport master (output addr, input data);
    modport slave  (input addr, output data);
endinterface

// File: rtl/pupil_locator_raster_addr_gen.sv
// Raster-order x/y/address counters for one H_RES x V_RES frame scan.
module raster_addr_gen #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int ADDR_W  = 15,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  addr,
    output logic               last
);
    logic x_wrap;

    assign x_wrap = (x == COORD_W'(H_RES - 1));
    assign last   = x_wrap && (y == COORD_W'(V_RES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (x_wrap) begin
                x <= '0;
                y <= y + COORD_W'(1);
            end else begin
                x <= x + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/pupil_locator.sv
// Single-pass raster scan of the frame RAM: thresholds each pixel, tracks the
// dark-pixel bounding box and count, and reports the box centre as the pupil.
module pupil_locator
    import pupil_locator_pkg::*;
#(
    parameter int H_RES      = pupil_locator_pkg::H_RES,
    parameter int V_RES      = pupil_locator_pkg::V_RES,
    parameter int DATA_W     = pupil_locator_pkg::DATA_W,
    parameter int ADDR_W     = pupil_locator_pkg::ADDR_W,
    parameter int COORD_W    = pupil_locator_pkg::COORD_W,
    parameter int MIN_PIXELS = pupil_locator_pkg::MIN_PIXELS
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic [DATA_W-1:0]  iThreshold,
    pupil_locator_if.master    mem,
    output logic               oBusy,
    output logic               oDone,
    output logic               oFound,
    output logic [COORD_W-1:0] oCenterX,
    output logic [COORD_W-1:0] oCenterY,
    output logic [ADDR_W-1:0]  oPixelCount
);
    state_t state, state_next;

    logic               start, advance, last;
    logic [COORD_W-1:0] x, y, x_d, y_d;
    logic               pix_valid, dark, found;
    logic [DATA_W-1:0]  threshold;
    logic [ADDR_W-1:0]  count;
    logic [COORD_W-1:0] min_x, max_x, min_y, max_y;
    logic [COORD_W:0]   sum_x, sum_y;

    assign start   = (state == IDLE) && iStart;
    assign advance = (state == SCAN) && !last;
    assign dark    = pix_valid && (mem.data <= threshold);
    assign found   = (count >= ADDR_W'(MIN_PIXELS));
    assign sum_x   = {1'b0, min_x} + {1'b0, max_x};
    assign sum_y   = {1'b0, min_y} + {1'b0, max_y};

    raster_addr_gen #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .ADDR_W  (ADDR_W),
        .COORD_W (COORD_W)
    ) u_addr_gen (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .clear   (start),
        .advance (advance),
        .x       (x),
        .y       (y),
        .addr    (mem.addr),
        .last    (last)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (iStart) state_next = SCAN;
            SCAN:    if (last) state_next = DRAIN;
            DRAIN:   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // x_d/y_d/pix_valid line up with iMemData, which lags the address by one cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            pix_valid <= 1'b0;
            x_d       <= '0;
            y_d       <= '0;
            threshold <= '0;
            count     <= '0;
            min_x     <= '1;
            min_y     <= '1;
            max_x     <= '0;
            max_y     <= '0;
        end else begin
            pix_valid <= (state == SCAN);
            x_d       <= x;
            y_d       <= y;
            if (start) begin
                threshold <= iThreshold;
                count     <= '0;
                min_x     <= '1;
                min_y     <= '1;
                max_x     <= '0;
                max_y     <= '0;
            end else if (dark) begin
                if (count != '1) count <= count + ADDR_W'(1);
                if (x_d < min_x) min_x <= x_d;
                if (x_d > max_x) max_x <= x_d;
                if (y_d < min_y) min_y <= y_d;
                if (y_d > max_y) max_y <= y_d;
            end
        end
    end

    // Results load as FINISH is left, so oDone/oBusy share the cycle after FINISH.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oFound      <= 1'b0;
            oCenterX    <= '0;
            oCenterY    <= '0;
            oPixelCount <= '0;
        end else begin
            oBusy <= (state == IDLE) ? iStart : 1'b1;
            oDone <= (state == FINISH);
            if (state == FINISH) begin
                oFound      <= found;
                oPixelCount <= count;
                oCenterX    <= found ? sum_x[COORD_W:1] : '0;
                oCenterY    <= found ? sum_y[COORD_W:1] : '0;
            end
        end
    end

endmodule

// File: tb/tb_pupil_locator.sv
// Bench for pupil_locator: four independent channels (three full-size, one
// small window) checked against a whole-frame behavioural model.
module tb_pupil_locator;

    localparam int NCH = 4;

    typedef struct {
        int count;
        int found;
        int cx;
        int cy;
    } res_t;

    function automatic int hres(input int c);
        return (c == 3) ? 16 : 160;
    endfunction

    function automatic int vres(input int c);
        return (c == 3) ? 12 : 120;
    endfunction

    function automatic int minpix(input int c);
        return (c == 2) ? 2 : 16;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n [NCH];
    logic        start [NCH];
    logic [9:0]  thr   [NCH];
    logic        busy  [NCH];
    logic        done  [NCH];
    logic        found [NCH];
    logic [7:0]  cx    [NCH];
    logic [7:0]  cy    [NCH];
    logic [14:0] cnt   [NCH];
    logic [14:0] addr  [NCH];

    logic [9:0]  frame [NCH][19200];
    res_t        exp_res [NCH];
    int          armed [NCH];
    int          dones [NCH];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endfunction

    function automatic res_t model(input int c, input int t);
        res_t r;
        int n = 0;
        int mnx = 1 << 20, mxx = -1, mny = 1 << 20, mxy = -1;
        for (int yy = 0; yy < vres(c); yy++)
            for (int xx = 0; xx < hres(c); xx++)
                if (int'(frame[c][xx + hres(c) * yy]) <= t) begin
                    n++;
                    if (xx < mnx) mnx = xx;
                    if (xx > mxx) mxx = xx;
                    if (yy < mny) mny = yy;
                    if (yy > mxy) mxy = yy;
                end
        r.count = n;
        r.found = (n >= minpix(c)) ? 1 : 0;
        r.cx    = r.found ? (mnx + mxx) / 2 : 0;
        r.cy    = r.found ? (mny + mxy) / 2 : 0;
        return r;
    endfunction

    function automatic void fill(input int c, input int v);
        for (int i = 0; i < hres(c) * vres(c); i++) frame[c][i] = 10'(v);
    endfunction

    function automatic void rect(input int c, input int x0, input int x1,
                                 input int y0, input int y1, input int v);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++) frame[c][xx + hres(c) * yy] = 10'(v);
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : ch
        pupil_locator_if #(.ADDR_W(15), .DATA_W(10)) mem_if ();

        pupil_locator #(
            .H_RES      (hres(g)),
            .V_RES      (vres(g)),
            .DATA_W     (10),
            .ADDR_W     (15),
            .COORD_W    (8),
            .MIN_PIXELS (minpix(g))
        ) dut (
            .iCLK        (clk),
            .iRST_N      (rst_n[g]),
            .iStart      (start[g]),
            .iThreshold  (thr[g]),
            .mem         (mem_if),
            .oBusy       (busy[g]),
            .oDone       (done[g]),
            .oFound      (found[g]),
            .oCenterX    (cx[g]),
            .oCenterY    (cy[g]),
            .oPixelCount (cnt[g])
        );

        always @(posedge clk) mem_if.data <= frame[g][int'(mem_if.addr)];
        assign addr[g] = mem_if.addr;

        res_t held;

        always @(negedge clk) begin
            if (!rst_n[g]) begin
                held = '{0, 0, 0, 0};
                chk($sformatf("ch%0d reset busy", g), int'(busy[g]), 0);
                chk($sformatf("ch%0d reset done", g), int'(done[g]), 0);
                chk($sformatf("ch%0d reset count", g), int'(cnt[g]), 0);
                chk($sformatf("ch%0d reset cx", g), int'(cx[g]), 0);
            end else if (done[g]) begin
                if (dones[g] >= armed[g]) begin
                    chk($sformatf("ch%0d unexpected done", g), 1, 0);
                end else begin
                    chk($sformatf("ch%0d done found", g), int'(found[g]), exp_res[g].found);
                    chk($sformatf("ch%0d done count", g), int'(cnt[g]), exp_res[g].count);
                    chk($sformatf("ch%0d done cx", g), int'(cx[g]), exp_res[g].cx);
                    chk($sformatf("ch%0d done cy", g), int'(cy[g]), exp_res[g].cy);
                    held = exp_res[g];
                end
                dones[g]++;
            end else begin
                chk($sformatf("ch%0d hold found", g), int'(found[g]), held.found);
                chk($sformatf("ch%0d hold count", g), int'(cnt[g]), held.count);
                chk($sformatf("ch%0d hold cx", g), int'(cx[g]), held.cx);
                chk($sformatf("ch%0d hold cy", g), int'(cy[g]), held.cy);
            end
        end
    end

    // One scan on channel c. skip: the start edge has just happened (held iStart).
    task automatic scan(input int c, input int t, input bit pulses, input int rst_at,
                        input bit keep, input bit skip);
        int cyc, npix, ea;
        bit addr_ok, busy_ok;
        npix = hres(c) * vres(c);
        exp_res[c] = model(c, t);
        armed[c]++;
        if (!skip) begin
            @(negedge clk);
            thr[c]   = 10'(t);
            start[c] = 1'b1;
            @(posedge clk);
            #1;
        end
        start[c] = keep;
        thr[c]   = 10'($urandom_range(0, 1023));
        cyc = 0;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        while (done[c] !== 1'b1 && cyc < 25000) begin
            ea = (cyc < npix) ? cyc : npix - 1;
            if (int'(addr[c]) != ea) addr_ok = 1'b0;
            if (busy[c] !== 1'b1) busy_ok = 1'b0;
            if (cyc == rst_at) begin
                rst_n[c] = 1'b0;
                armed[c]--;
                start[c] = 1'b0;
                #1;
                chk($sformatf("ch%0d async rst addr", c), int'(addr[c]), 0);
                chk($sformatf("ch%0d async rst busy", c), int'(busy[c]), 0);
                chk($sformatf("ch%0d async rst done", c), int'(done[c]), 0);
                chk($sformatf("ch%0d async rst found", c), int'(found[c]), 0);
                chk($sformatf("ch%0d async rst cx", c), int'(cx[c]), 0);
                chk($sformatf("ch%0d async rst cy", c), int'(cy[c]), 0);
                chk($sformatf("ch%0d async rst count", c), int'(cnt[c]), 0);
                return;
            end
            if (pulses) start[c] = (cyc == 100 || cyc == npix + 1);
            @(posedge clk);
            #1;
            cyc++;
        end
        start[c] = keep;
        chk($sformatf("ch%0d done latency", c), cyc, npix + 2);
        chk($sformatf("ch%0d address sequence ok", c), int'(addr_ok), 1);
        chk($sformatf("ch%0d busy through scan", c), int'(busy_ok), 1);
        chk($sformatf("ch%0d busy at done", c), int'(busy[c]), 1);
        if (!keep) begin
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("ch%0d idle after done", c), int'(busy[c]), 0);
        end
    endtask

    initial begin
        int nb, x0, x1, y0, y1;
        for (int c = 0; c < NCH; c++) begin
            rst_n[c] = 1'b0;
            start[c] = 1'b0;
            thr[c]   = '0;
            armed[c] = 0;
            dones[c] = 0;
        end
        fill(0, 900);
        rect(0, 40, 59, 30, 49, 50);
        for (int c = 1; c <= 2; c++) begin
            fill(c, 900);
            frame[c][0]     = 10'd10;
            frame[c][19199] = 10'd10;
        end
        fill(3, 1023);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < NCH; c++) rst_n[c] = 1'b1;

        fork
            begin
                scan(0, 100, 1'b1, -1, 1'b0, 1'b0);
                chk("blob t100 count", int'(cnt[0]), 400);
                chk("blob t100 found", int'(found[0]), 1);
                chk("blob t100 cx", int'(cx[0]), 49);
                chk("blob t100 cy", int'(cy[0]), 39);
                scan(0, 100, 1'b0, 5000, 1'b0, 1'b0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n[0] = 1'b1;
                repeat (20) @(posedge clk);
                #1;
                chk("post-reset busy", int'(busy[0]), 0);
                scan(0, 50, 1'b0, -1, 1'b1, 1'b0);
                chk("blob t50 count", int'(cnt[0]), 400);
                chk("blob t50 found", int'(found[0]), 1);
                chk("blob t50 cx", int'(cx[0]), 49);
                chk("blob t50 cy", int'(cy[0]), 39);
                thr[0] = 10'd49;
                @(posedge clk);
                #1;
                chk("back-to-back addr restart", int'(addr[0]), 0);
                chk("back-to-back busy", int'(busy[0]), 1);
                scan(0, 49, 1'b0, -1, 1'b0, 1'b1);
                chk("blob t49 count", int'(cnt[0]), 0);
                chk("blob t49 found", int'(found[0]), 0);
                chk("blob t49 cx", int'(cx[0]), 0);
            end
            begin
                fork
                    scan(1, 100, 1'b0, -1, 1'b0, 1'b0);
                    scan(2, 100, 1'b0, -1, 1'b0, 1'b0);
                join
                chk("corners min16 count", int'(cnt[1]), 2);
                chk("corners min16 found", int'(found[1]), 0);
                chk("corners min16 cx", int'(cx[1]), 0);
                chk("corners min2 count", int'(cnt[2]), 2);
                chk("corners min2 found", int'(found[2]), 1);
                chk("corners min2 cx", int'(cx[2]), 79);
                chk("corners min2 cy", int'(cy[2]), 59);
                fill(1, 1023);
                scan(1, 100, 1'b0, -1, 1'b0, 1'b0);
                chk("bright count", int'(cnt[1]), 0);
                chk("bright found", int'(found[1]), 0);
                chk("bright cy", int'(cy[1]), 0);
            end
            begin
                for (int it = 0; it < 30; it++) begin
                    for (int i = 0; i < 192; i++) frame[3][i] = 10'($urandom_range(200, 1023));
                    nb = $urandom_range(0, 3);
                    for (int b = 0; b < nb; b++) begin
                        x0 = $urandom_range(0, 15);
                        x1 = $urandom_range(x0, 15);
                        y0 = $urandom_range(0, 11);
                        y1 = $urandom_range(y0, 11);
                        rect(3, x0, x1, y0, y1, $urandom_range(0, 300));
                    end
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    scan(3, $urandom_range(0, 350), it[0], -1, 1'b0, 1'b0);
                end
            end
        join

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pupil_locator.md
Name: pupil_locator

Overview:
- Downstream consumer of the frame-capture stage.
- After one H_RES x V_RES luminance window has been written to on-chip frame RAM, scans the RAM once in raster order.
- Thresholds each pixel and tracks the bounding box and count of dark pixels.
- Reports the box centre as the pupil estimate for the overlay/LED logic.

Parameters:
- H_RES, 160, window width in pixels
- V_RES, 120, window height in pixels
- DATA_W, 10, stored pixel width
- ADDR_W, 15, frame RAM address width (H_RES*V_RES <= 2^ADDR_W)
- COORD_W, 8, coordinate width (H_RES, V_RES <= 2^COORD_W)
- MIN_PIXELS, 16, minimum dark-pixel count for a valid detection

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iStart  in  1  start scan (level sampled in IDLE only)
- iThreshold  in  DATA_W  dark threshold; latched at start
- oMemAddr  out  ADDR_W  frame RAM read address, row-major: x + H_RES*y
- iMemData  in  DATA_W  frame RAM read data, valid one cycle after address
- oBusy  out  1  high from accepted start until oDone cycle inclusive
- oDone  out  1  one-cycle pulse, results valid
- oFound  out  1  dark count >= MIN_PIXELS
- oCenterX  out  COORD_W  (minX+maxX)>>1
- oCenterY  out  COORD_W  (minY+maxY)>>1
- oPixelCount  out  ADDR_W  dark pixels in last scan, saturating

Behaviour:
Reset:
- State IDLE.
- oMemAddr, oBusy, oDone, oFound, oCenterX, oCenterY, oPixelCount all 0.
- Internal min registers are set to all-ones; max registers are set to 0.

FSM IDLE -> SCAN -> DRAIN -> FINISH -> IDLE.
- IDLE, iStart=1 at edge E:
  - Latch iThreshold.
  - Clear count; set minX/minY to all-ones and maxX/maxY to 0.
  - Set x=y=0 and oMemAddr=0.
  - Go to SCAN; oBusy=1 from E.
- SCAN:
  - Each cycle advance x; at x=H_RES-1, x wraps to 0 and y increments.
  - oMemAddr increments by 1 each cycle (row-major, no gaps).
  - One-cycle delayed copies of x and y, plus a valid bit, pair with iMemData.
  - After the address for (H_RES-1, V_RES-1) is issued, go to DRAIN.
- DRAIN:
  - Processes the last pixel.
  - oMemAddr holds its last value.
- Pixel rule: dark iff iMemData <= latched threshold (equality counts as dark). For each dark pixel:
  - count += 1, saturating at 2^ADDR_W-1.
  - minX = min(minX, x); maxX = max(maxX, x); same for Y.
- FINISH:
  - Register the outputs.
  - oFound = (count >= MIN_PIXELS).
  - If found: centre = (min+max)>>1, computed with a COORD_W+1 bit sum. Otherwise oCenterX = oCenterY = 0.
  - oPixelCount = count, regardless of found.
  - oDone=1 for this cycle only; oBusy=1.
  - Next state IDLE.
- Latency: oDone is high in the cycle H_RES*V_RES+2 edges after E (19202 at defaults).
- Outputs hold until the next FINISH. A new scan does not clear them early.
- iStart while oBusy=1 (including the FINISH cycle) is ignored; there is no queuing.
- iStart held high continuously: a new scan starts on the first edge in IDLE, i.e. the cycle after oDone.
- iThreshold changes during a scan have no effect.
- iRST_N low at any time (including mid-scan): immediate return to reset values. A partial scan produces no oDone.

Decomposition:
- The shared parameter header (alongside the capture-window constants) holds H_RES, V_RES, ADDR_W, DATA_W and the state encodings IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2, FINISH=2'd3. The capture stage and this block must agree on window size and addressing.
- One natural sub-module: raster_addr_gen, containing the x/y/address counters, wrap logic and last-pixel flag. Threshold and bounding-box datapath stay in the top.

Test Plan:
- All pixels 1023, threshold 100 -> count 0, oFound=0, centre (0,0); oDone exactly 19202 cycles after start edge.
- Pixels 50 in block x 40..59, y 30..49, else 900; threshold 100 -> count 400, oFound=1, centre (49,39); addresses 0..19199 each issued once, in order.
- Same frame, threshold 50 (equality) -> identical result; threshold 49 -> count 0, oFound=0.
- Dark pixels only at (0,0) and (159,119), MIN_PIXELS=2 -> count 2, found, centre (79,59); with default MIN_PIXELS -> oFound=0, oPixelCount=2.
- iStart pulsed at cycles 100 and 19201 of a scan -> single oDone, second pulse ignored; iStart held high -> back-to-back scans, next SCAN begins the cycle after oDone.
- Assert iRST_N low at scan cycle 5000 with a 400-pixel dark blob -> all outputs 0 immediately, no oDone; a restart then gives the full correct result.
